d_cache_ctrl: RTL and testbench

D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

---
 rtl/d_cache_ctrl_if.sv | 42 ++++
 rtl/d_cache_ctrl.sv | 126 ++++++++++++
 tb/tb_d_cache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_ctrl_if.sv
// Signal bundle between the lookup stage, the cache controller and the memory port.
// The controller uses the slave view; the lookup stage and memory model use the master view.
interface d_cache_ctrl_if;
  // lookup stage -> controller
  logic             in_req;
  logic             hit_i;
  logic             miss_i;
  logic [27:0]      tagid_i;
  logic [1:0]       lineid_i;
  logic [1:0]       wordid_i;
  logic             we_i;
  logic [31:0]      wdata_i;

  // controller -> lookup stage
  logic [3:0][27:0] tag_array_ctrl;
  logic [3:0]       valid_array_ctrl;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      rdata_o;

  // controller <-> memory
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;
  logic             mem_ack_i;

  modport slave (
    input  in_req, hit_i, miss_i, tagid_i, lineid_i, wordid_i, we_i, wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output tag_array_ctrl, valid_array_ctrl, busy_o, done_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output in_req, hit_i, miss_i, tagid_i, lineid_i, wordid_i, we_i, wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  tag_array_ctrl, valid_array_ctrl, busy_o, done_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped data cache controller: 4 lines x 4 words, line refill on load miss,
// write-through / no-write-allocate stores, one-cycle done pulse per request.
module d_cache_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  d_cache_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  state_t      state;
  logic [27:0] tag_q;
  logic [1:0]  line_q;
  logic [1:0]  word_q;
  logic [1:0]  cnt;
  logic        hit_q;
  logic [31:0] wdata_q;

  logic [31:0] data_mem [0:3][0:3];

  logic eff_hit;
  logic ack;

  // The raw tag compare is only trusted once the line has been filled.
  assign eff_hit = bus.hit_i & bus.valid_array_ctrl[bus.lineid_i];
  assign ack     = bus.mem_ack_i & bus.mem_req_o;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // update in this block sees the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      tag_q                <= '0;
      line_q               <= '0;
      word_q               <= '0;
      hit_q                <= 1'b0;
      wdata_q              <= '0;
      bus.tag_array_ctrl   <= '0;
      bus.valid_array_ctrl <= '0;
      bus.busy_o           <= 1'b0;
      bus.done_o           <= 1'b0;
      bus.rdata_o          <= '0;
      bus.mem_req_o        <= 1'b0;
      bus.mem_we_o         <= 1'b0;
      bus.mem_addr_o       <= '0;
      bus.mem_wdata_o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_req) begin
            tag_q      <= bus.tagid_i;
            line_q     <= bus.lineid_i;
            word_q     <= bus.wordid_i;
            hit_q      <= eff_hit;
            wdata_q    <= bus.wdata_i;
            bus.busy_o <= 1'b1;
            if (bus.we_i) begin
              state           <= WRITE;
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= 1'b1;
              bus.mem_addr_o  <= {bus.tagid_i, bus.lineid_i, bus.wordid_i};
              bus.mem_wdata_o <= bus.wdata_i;
            end else if (eff_hit) begin
              state       <= RESP;
              bus.done_o  <= 1'b1;
              bus.rdata_o <= data_mem[bus.lineid_i][bus.wordid_i];
            end else begin
              state          <= REFILL;
              cnt            <= '0;
              bus.mem_req_o  <= 1'b1;
              bus.mem_we_o   <= 1'b0;
              bus.mem_addr_o <= {bus.tagid_i, bus.lineid_i, 2'd0};
            end
          end
        end

        REFILL: begin
          if (ack) begin
            if (cnt == 2'd3) begin
              bus.tag_array_ctrl[line_q]   <= tag_q;
              bus.valid_array_ctrl[line_q] <= 1'b1;
              bus.mem_req_o                <= 1'b0;
              bus.done_o                   <= 1'b1;
              // The last word is still on the bus; earlier words are already in the array.
              bus.rdata_o <= (word_q == 2'd3) ? bus.mem_rdata_i : data_mem[line_q][word_q];
              cnt         <= '0;
              state       <= RESP;
            end else begin
              cnt            <= cnt + 2'd1;
              bus.mem_addr_o <= {tag_q, line_q, cnt + 2'd1};
            end
          end
        end

        WRITE: begin
          if (ack) begin
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.done_o    <= 1'b1;
            bus.rdata_o   <= '0;
            state         <= RESP;
          end
        end

        RESP: begin
          bus.done_o <= 1'b0;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the data array has no reset; its contents only matter once the valid
  // bit of the line is set, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == REFILL && ack)
      data_mem[line_q][cnt] <= bus.mem_rdata_i;
    else if (state == WRITE && ack && hit_q)
      data_mem[line_q][word_q] <= wdata_q;
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl: a memory model answers the refill/write port, a
// scoreboard queue holds expected completions and a negedge monitor checks done_o.
module tb_d_cache_ctrl;

  typedef struct {
    logic [31:0] rdata;
    int          lat;    // 0 = latency not checked
    int          issue;  // edge index that launched in_req
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   ack_delay;
  int   req_cycles;

  exp_t                sb[$];
  mem_txn_t            mem_log[$];
  logic [31:0]         mem_store[logic [31:0]];

  d_cache_ctrl_if bus ();

  d_cache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: written words override a fixed address pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: acks after ack_delay cycles of mem_req_o, back to back for refills.
  initial begin
    int wait_cnt;
    wait_cnt        = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && bus.mem_req_o) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          wait_cnt      = 0;
          bus.mem_ack_i = 1'b1;
          mem_log.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
          if (bus.mem_we_o) mem_store[bus.mem_addr_o] = bus.mem_wdata_o;
          else              bus.mem_rdata_i = mem_word(bus.mem_addr_o);
        end else begin
          bus.mem_ack_i = 1'b0;
        end
      end else begin
        bus.mem_ack_i = 1'b0;
        wait_cnt      = 0;
      end
    end
  end

  // Monitor: every done_o cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.mem_req_o) req_cycles++;
    if (rst_n && bus.done_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_o=1 with rdata %0h, expected no completion", bus.rdata_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", bus.rdata_o, e.rdata);
        if (e.lat != 0) check("done_latency", cyc + 1 - e.issue, e.lat);
      end
    end
  end

  task automatic issue(input logic [27:0] tag, input logic [1:0] line, input logic [1:0] word,
                       input logic we, input logic [31:0] wd, input logic hit,
                       input bit expect_done, input logic [31:0] exp_rd, input int exp_lat);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (bus.busy_o !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("issue_wait_timeout", 1, 0);
    bus.in_req   = 1'b1;
    bus.tagid_i  = tag;
    bus.lineid_i = line;
    bus.wordid_i = word;
    bus.we_i     = we;
    bus.wdata_i  = wd;
    bus.hit_i    = hit;
    bus.miss_i   = ~hit;
    if (expect_done) sb.push_back('{exp_rd, exp_lat, cyc});
    @(posedge clk);
    #1;
    // Scramble the fields after acceptance; the controller must use its captured copy.
    bus.in_req   = 1'b0;
    bus.tagid_i  = ~tag;
    bus.wordid_i = ~word;
    bus.we_i     = ~we;
    bus.wdata_i  = ~wd;
    bus.hit_i    = 1'b0;
    bus.miss_i   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy_o !== 1'b0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_refill_log(input string name, input logic [31:0] base);
    check({name, "_count"}, mem_log.size(), 4);
    for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
      check({name, "_addr"}, mem_log[i].addr, base + i);
      check({name, "_we"}, mem_log[i].we, 0);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc          = 0;
    ack_delay    = 1;
    req_cycles   = 0;
    rst_n        = 1'b0;
    bus.in_req   = 1'b0;
    bus.hit_i    = 1'b0;
    bus.miss_i   = 1'b0;
    bus.tagid_i  = '0;
    bus.lineid_i = '0;
    bus.wordid_i = '0;
    bus.we_i     = 1'b0;
    bus.wdata_i  = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wdata", bus.mem_wdata_o, 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_valid", bus.valid_array_ctrl, 0);
    check("rst_tags", bus.tag_array_ctrl[0] | bus.tag_array_ctrl[1] | bus.tag_array_ctrl[2] | bus.tag_array_ctrl[3], 0);
    rst_n = 1'b1;

    // Load miss with a spurious raw hit: refill 0x18..0x1B, return word at 0x19.
    mem_log.delete();
    issue(28'h0000001, 2'd2, 2'd1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0019_FFE6, 0);
    wait_idle();
    check_refill_log("refill1", 32'h18);
    check("refill1_valid2", bus.valid_array_ctrl[2], 1);
    check("refill1_tag2", bus.tag_array_ctrl[2], 28'h0000001);

    // Same load hits: done two edges after launch, no memory traffic.
    mem_log.delete();
    req_cycles = 0;
    issue(28'h0000001, 2'd2, 2'd1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0019_FFE6, 2);
    wait_idle();
    check("hit_no_mem_txn", mem_log.size(), 0);
    check("hit_no_mem_req", req_cycles, 0);

    // Store hit with a 5-cycle ack; rdata_o reads 0 on store completion.
    mem_log.delete();
    req_cycles = 0;
    ack_delay  = 5;
    issue(28'h0000001, 2'd2, 2'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, 0);
    @(negedge clk);
    check("store_busy", bus.busy_o, 1);
    wait_idle();
    check("store_req_cycles", req_cycles, 5);
    check("store_txn_count", mem_log.size(), 1);
    if (mem_log.size() > 0) begin
      check("store_we", mem_log[0].we, 1);
      check("store_addr", mem_log[0].addr, 32'h1B);
      check("store_wdata", mem_log[0].data, 32'hDEAD_BEEF);
    end
    ack_delay = 1;
    issue(28'h0000001, 2'd2, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2);
    wait_idle();

    // Store miss to another tag on line 2: written through, line untouched.
    mem_log.delete();
    issue(28'h0000002, 2'd2, 2'd3, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 0);
    wait_idle();
    check("smiss_txn_count", mem_log.size(), 1);
    if (mem_log.size() > 0) check("smiss_addr", mem_log[0].addr, 32'h2B);
    check("smiss_valid2", bus.valid_array_ctrl[2], 1);
    check("smiss_tag2", bus.tag_array_ctrl[2], 28'h0000001);
    issue(28'h0000001, 2'd2, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2);
    wait_idle();

    // in_req pulsed mid-refill is ignored.
    mem_log.delete();
    ack_delay = 2;
    issue(28'h0000003, 2'd1, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0036_FFC9, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.in_req   = 1'b1;
    bus.tagid_i  = 28'h0000005;
    bus.lineid_i = 2'd0;
    bus.we_i     = 1'b1;
    bus.wdata_i  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    bus.in_req = 1'b0;
    bus.we_i   = 1'b0;
    wait_idle();
    check_refill_log("refill2", 32'h34);
    check("refill2_valid1", bus.valid_array_ctrl[1], 1);

    // Reset after the second refill ack aborts the refill.
    mem_log.delete();
    ack_delay = 1;
    issue(28'h0000004, 2'd0, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    begin
      int n;
      n = 0;
      while (mem_log.size() < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("abort_wait_timeout", 1, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", bus.mem_req_o, 0);
    check("abort_valid", bus.valid_array_ctrl, 0);
    check("abort_busy", bus.busy_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_txn_count", mem_log.size(), 2);
    if (mem_log.size() == 2) begin
      check("abort_addr0", mem_log[0].addr, 32'h41 - 1);
      check("abort_addr1", mem_log[1].addr, 32'h41);
    end

    // After reset line 2 is invalid again: refill from word 0, stored word comes back.
    mem_log.delete();
    issue(28'h0000001, 2'd2, 2'd3, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
    wait_idle();
    check_refill_log("refill3", 32'h18);
    check("refill3_valid2", bus.valid_array_ctrl[2], 1);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
